pair_pick_ctrl: RTL

Synchronous sequencer for the two-card "pick and add" step of the card game. It owns the cursor over the 2×5 card grid, registers button edges, and walks an FSM through first pick, second pick and sum. It issues a one-cycle result/clear strobe to the board-state logic and alternates the active player. It replaces edge-triggered button logic with single-clock sampling.

---
 rtl/pair_pick_ctrl.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pair_pick_ctrl.sv
// pair_pick_ctrl: cursor, button-edge and pick/sum sequencer for the two-card
// "pick and add" step. Walks IDLE -> FIRST -> SUM -> DONE, emits a one-cycle
// result/clear strobe and alternates the active player.
// Optional feature: define PICK_TIMEOUT_EN to abandon a first pick after
// TIMEOUT_CYCLES cycles in FIRST without a valid second pick.
module pair_pick_ctrl #(
    parameter int COLS           = 5,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  num,
    input  logic [39:0] status,
    input  logic [3:0]  buttons,
    input  logic        btn,
    output logic [3:0]  cursor,
    output logic [3:0]  first_index,
    output logic        sel_valid,
    output logic [3:0]  result,
    output logic        result_valid,
    output logic [9:0]  clear_mask,
    output logic        clear_en,
    output logic        player,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SUM,
        DONE
    } state_t;

    localparam int         NUM_SLOTS = 10;
    localparam logic [3:0] COLS_W    = 4'(COLS);
    localparam logic [3:0] NO_SLOT   = 4'hF;

    state_t      state_q, state_d;
    logic [3:0]  cursor_q, cursor_d;
    logic [3:0]  first_q, first_d;
    logic [3:0]  second_q, second_d;
    logic [3:0]  val_a_q, val_a_d;
    logic [3:0]  val_b_q, val_b_d;
    logic [3:0]  result_q, result_d;
    logic        result_valid_q, result_valid_d;
    logic        clear_en_q, clear_en_d;
    logic [9:0]  clear_mask_q, clear_mask_d;
    logic        player_q, player_d;
    logic        error_q, error_d;
    logic        sel_valid_q, sel_valid_d;
    logic [3:0]  buttons_hist_q;
    logic        btn_hist_q;

    logic [3:0]  dir_ev;
    logic        confirm_ev;
    logic [3:0]  num_eff;
    logic [3:0]  last_col;
    logic        cur_row;
    logic [3:0]  cur_col;
    logic [3:0]  col_c;
    logic        new_row;
    logic [3:0]  new_col;
    logic [3:0]  moved_cursor;
    logic [3:0]  cur_val;
    logic        valid_second;
    logic [4:0]  pair_sum;
    logic        timeout_hit;

    assign dir_ev     = buttons & ~buttons_hist_q;
    assign confirm_ev = btn & ~btn_hist_q;

    // Effective column count: 0 behaves as 1, anything above COLS clamps to COLS.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        num_eff = {1'b0, num};
        if (num == 3'd0) begin
            num_eff = 4'd1;
        end else if ({1'b0, num} > COLS_W) begin
            num_eff = COLS_W;
        end
    end

    // Card value under the cursor, selected slot by slot from the packed status bus.
    always_comb begin
        cur_val = 4'd0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (cursor_q == 4'(s)) begin
                cur_val = status[4*s +: 4];
            end
        end
    end

    // Next cursor position: clamp a stale column first, then apply the highest-priority move.
    always_comb begin
        last_col = num_eff - 4'd1;
        cur_row  = (cursor_q >= COLS_W);
        cur_col  = cur_row ? (cursor_q - COLS_W) : cursor_q;
        col_c    = (cur_col >= num_eff) ? last_col : cur_col;
        new_row  = cur_row;
        new_col  = col_c;
        if (dir_ev[0] || dir_ev[1]) begin
            new_row = ~cur_row;
        end else if (dir_ev[2]) begin
            if (col_c == 4'd0) begin
                new_row = ~cur_row;
                new_col = last_col;
            end else begin
                new_col = col_c - 4'd1;
            end
        end else if (dir_ev[3]) begin
            if (col_c == last_col) begin
                new_row = ~cur_row;
                new_col = 4'd0;
            end else begin
                new_col = col_c + 4'd1;
            end
        end
        moved_cursor = new_row ? (new_col + COLS_W) : new_col;
    end

`ifdef PICK_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TW-1:0] tmo_q, tmo_d;

    // Second-pick timer: cleared on entry to FIRST, counts every cycle spent there.
    always_comb begin
        timeout_hit = (state_q == FIRST) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
        tmo_d       = ((state_q == FIRST) && (state_d == FIRST)) ? tmo_q + TW'(1) : '0;
    end

    // Timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Pick sequencer: next state plus every registered output for the coming cycle.
    always_comb begin
        state_d        = state_q;
        cursor_d       = cursor_q;
        first_d        = first_q;
        second_d       = second_q;
        val_a_d        = val_a_q;
        val_b_d        = val_b_q;
        result_d       = result_q;
        player_d       = player_q;
        result_valid_d = 1'b0;
        clear_en_d     = 1'b0;
        clear_mask_d   = '0;
        error_d        = 1'b0;
        valid_second   = confirm_ev && (cursor_q != first_q) && (cur_val != 4'd0);
        pair_sum       = {1'b0, val_a_q} + {1'b0, val_b_q};

        case (state_q)
            IDLE: begin
                cursor_d = moved_cursor;
                if (confirm_ev) begin
                    if (cur_val != 4'd0) begin
                        first_d = cursor_q;
                        val_a_d = cur_val;
                        state_d = FIRST;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            FIRST: begin
                cursor_d = moved_cursor;
                if (valid_second) begin
                    second_d = cursor_q;
                    val_b_d  = cur_val;
                    state_d  = SUM;
                end else begin
                    error_d = confirm_ev || timeout_hit;
                    if (timeout_hit) begin
                        first_d = NO_SLOT;
                        state_d = IDLE;
                    end
                end
            end
            SUM: begin
                if (pair_sum >= 5'd30) begin
                    result_d = 4'(pair_sum - 5'd30);
                end else if (pair_sum >= 5'd20) begin
                    result_d = 4'(pair_sum - 5'd20);
                end else if (pair_sum >= 5'd10) begin
                    result_d = 4'(pair_sum - 5'd10);
                end else begin
                    result_d = pair_sum[3:0];
                end
                result_valid_d = 1'b1;
                clear_en_d     = 1'b1;
                clear_mask_d   = (10'd1 << first_q) | (10'd1 << second_q);
                player_d       = ~player_q;
                cursor_d       = 4'd0;
                first_d        = NO_SLOT;
                state_d        = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sel_valid_d = (state_d == FIRST);
    end

    // State, output and edge-history registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q        <= IDLE;
            cursor_q       <= 4'd0;
            first_q        <= NO_SLOT;
            second_q       <= NO_SLOT;
            val_a_q        <= 4'd0;
            val_b_q        <= 4'd0;
            result_q       <= 4'd0;
            result_valid_q <= 1'b0;
            clear_en_q     <= 1'b0;
            clear_mask_q   <= '0;
            player_q       <= 1'b0;
            error_q        <= 1'b0;
            sel_valid_q    <= 1'b0;
            buttons_hist_q <= 4'd0;
            btn_hist_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cursor_q       <= cursor_d;
            first_q        <= first_d;
            second_q       <= second_d;
            val_a_q        <= val_a_d;
            val_b_q        <= val_b_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            clear_en_q     <= clear_en_d;
            clear_mask_q   <= clear_mask_d;
            player_q       <= player_d;
            error_q        <= error_d;
            sel_valid_q    <= sel_valid_d;
            buttons_hist_q <= buttons;
            btn_hist_q     <= btn;
        end
    end

    assign cursor       = cursor_q;
    assign first_index  = first_q;
    assign sel_valid    = sel_valid_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign clear_mask   = clear_mask_q;
    assign clear_en     = clear_en_q;
    assign player       = player_q;
    assign error        = error_q;

endmodule
